// File: rtl/switch_bounce_emulator_pkg.sv
// Shared types for the switch bounce emulator: FSM states and the 16-bit Galois LFSR.
// Pure package, no latency or backpressure of its own.
package switch_bounce_emulator_pkg;

  typedef enum logic [1:0] {IDLE, BOUNCE, SETTLE, DONE} state_t;

  localparam int unsigned       LFSR_W    = 16;
  // x^16 + x^14 + x^13 + x^11, right-shifting Galois form
  localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'hB400;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    lfsr_next = s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, loads SEED under synchronous active-low reset.
// Advances once per clock; no backpressure.
module lfsr16
  import switch_bounce_emulator_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  output logic [LFSR_W-1:0] o_state
);

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      o_state <= SEED;
    end else begin
      o_state <= lfsr_next(o_state);
    end
  end

endmodule

// File: rtl/switch_bounce_emulator.sv
// Mechanical switch emulator: first edge 1 cycle after accept, then LFSR-timed bounces and a settle hold.
// Requests are taken only when o_ready (IDLE); requests at other times are dropped, not queued.
module switch_bounce_emulator
  import switch_bounce_emulator_pkg::*;
#(
  parameter int unsigned       BOUNCE_COUNT  = 6,
  parameter int unsigned       MIN_GAP       = 64,
  parameter int unsigned       GAP_BITS      = 8,
  parameter int unsigned       SETTLE_CYCLES = 1000,
  parameter logic [LFSR_W-1:0] LFSR_SEED     = 16'hACE1
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_req,
  input  logic i_target,
  output logic o_ready,
  output logic o_bouncy_switch,
  output logic o_busy,
  output logic o_done
);

  localparam int unsigned GAP_W  = $clog2(MIN_GAP + (1 << GAP_BITS));
  localparam int unsigned SET_W  = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned EDGE_W = (BOUNCE_COUNT == 0) ? 1 : $clog2(2 * BOUNCE_COUNT + 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr;
  state_t            state_q, state_d;
  logic              level_q;
  logic [GAP_W-1:0]  gap_q, gap_load;
  logic [EDGE_W-1:0] edges_q;
  logic [SET_W-1:0]  settle_q;
  logic              accept, bounce_edge, last_edge, settle_end;

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_state (lfsr_q)
  );

  // only the low GAP_BITS feed the gap; the rest of the state is just the sequence
  assign unused_lfsr = ^lfsr_q;
  assign gap_load    = GAP_W'(MIN_GAP) + GAP_W'(lfsr_q[GAP_BITS-1:0]);

  assign accept      = i_req && (state_q == IDLE);
  assign bounce_edge = (state_q == BOUNCE) && (gap_q == GAP_W'(1));
  assign last_edge   = bounce_edge && (edges_q == EDGE_W'(1));
  assign settle_end  = (state_q == SETTLE) && (settle_q == SET_W'(1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // a same-level request skips straight to the settle hold
          if ((i_target != level_q) && (BOUNCE_COUNT != 0)) state_d = BOUNCE;
          else                                                state_d = SETTLE;
        end
      end
      BOUNCE:  if (last_edge)  state_d = SETTLE;
      SETTLE:  if (settle_end) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    o_ready = 1'b0;
    o_busy  = 1'b0;
    o_done  = 1'b0;
    case (state_q)
      IDLE:    o_ready = 1'b1;
      BOUNCE:  o_busy  = 1'b1;
      SETTLE:  o_busy  = 1'b1;
      DONE:    o_done  = 1'b1;
      default: o_ready = 1'b0;
    endcase
  end

  // every output edge reloads the gap and the settle window, so whichever edge is last arms SETTLE
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      level_q  <= 1'b0;
      gap_q    <= '0;
      edges_q  <= '0;
      settle_q <= '0;
    end else if (accept) begin
      level_q  <= i_target;
      gap_q    <= gap_load;
      edges_q  <= EDGE_W'(2 * BOUNCE_COUNT);
      settle_q <= SET_W'(SETTLE_CYCLES);
    end else if (bounce_edge) begin
      level_q  <= ~level_q;
      gap_q    <= gap_load;
      edges_q  <= edges_q - EDGE_W'(1);
      settle_q <= SET_W'(SETTLE_CYCLES);
    end else if (state_q == BOUNCE) begin
      if (gap_q != '0) gap_q <= gap_q - GAP_W'(1);
    end else if (state_q == SETTLE) begin
      if (settle_q != '0) settle_q <= settle_q - SET_W'(1);
    end
  end

  assign o_bouncy_switch = level_q;

endmodule

// File: tb/tb_switch_bounce_emulator.sv
// Randomized self-checking bench for switch_bounce_emulator against a cycle-count reference model.
module tb_switch_bounce_emulator;

  localparam int          BC     = 6;
  localparam int          MG     = 64;
  localparam int          GB     = 8;
  localparam int          SC     = 1000;
  localparam logic [15:0] SEED   = 16'hACE1;
  localparam int          MAXLEN = 1 + 2 * BC * (MG + (1 << GB) - 1) + SC + 1;

  logic clk = 1'b0;
  logic rst_n, req, tgt, rdy, sw, busy, done;
  logic req2, tgt2, rdy2, sw2, busy2, done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  logic [15:0] m_lfsr, m_prev;
  bit   mon_on;
  logic last_lvl;
  int   edge_cnt, done_cnt, busy_cnt, first_edge_cyc, last_edge_cyc, done_cyc, exp_gap;
  int   gaps[$];
  int   ref_gaps[$];

  switch_bounce_emulator #(
    .BOUNCE_COUNT(BC), .MIN_GAP(MG), .GAP_BITS(GB), .SETTLE_CYCLES(SC), .LFSR_SEED(SEED)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req), .i_target(tgt),
    .o_ready(rdy), .o_bouncy_switch(sw), .o_busy(busy), .o_done(done)
  );

  switch_bounce_emulator #(
    .BOUNCE_COUNT(0), .MIN_GAP(1), .GAP_BITS(1), .SETTLE_CYCLES(1), .LFSR_SEED(SEED)
  ) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_req(req2), .i_target(tgt2),
    .o_ready(rdy2), .o_bouncy_switch(sw2), .o_busy(busy2), .o_done(done2)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
  endfunction

  // reference LFSR: seed while reset is sampled low, one step per other clock
  always @(posedge clk) begin
    m_prev <= m_lfsr;
    if (!rst_n) m_lfsr <= SEED;
    else        m_lfsr <= lfsr_step(m_lfsr);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // one clock; sample on the falling edge and track edges, gaps, busy and done
  task automatic tick();
    int g;
    @(negedge clk);
    cyc++;
    if (mon_on) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (sw !== last_lvl) begin
        edge_cnt++;
        if (edge_cnt == 1) begin
          first_edge_cyc = cyc;
        end else begin
          g = cyc - last_edge_cyc;
          gaps.push_back(g);
          check_eq("gap_model", g, exp_gap);
          check_eq("gap_range", (g >= MG) && (g <= MG + (1 << GB) - 1), 1);
        end
        last_edge_cyc = cyc;
        exp_gap       = MG + int'(m_prev[GB-1:0]);
        last_lvl      = sw;
      end
    end
  endtask

  task automatic do_reset();
    mon_on = 0;
    req    = 1'b0;
    rst_n  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input logic t, input int delay, input bit noise, input int abort_after);
    logic start_lvl;
    int   acc_cyc, n_exp;
    req = 1'b0;
    repeat (delay) tick();
    start_lvl = sw;
    edge_cnt  = 0;
    done_cnt  = 0;
    busy_cnt  = 0;
    gaps.delete();
    last_lvl  = sw;
    mon_on    = 1;
    check_eq("idle_ready", rdy, 1);
    req = 1'b1;
    tgt = t;
    tick();
    acc_cyc = cyc;
    check_eq("acc_ready", rdy, 0);
    check_eq("acc_busy", busy, 1);
    req = 1'b0;
    for (int i = 0; i < MAXLEN + 20; i++) begin
      if (done_cnt != 0) break;
      if (abort_after != 0 && edge_cnt == abort_after) break;
      if (noise) begin
        req = 1'($urandom_range(0, 1));
        tgt = ~tgt;
      end
      tick();
    end
    req = 1'b0;
    if (abort_after != 0) begin
      check_eq("abort_edges", edge_cnt, abort_after);
      return;
    end
    n_exp = (t != start_lvl) ? 1 + 2 * BC : 0;
    check_eq("edge_count", edge_cnt, n_exp);
    if (n_exp != 0) check_eq("first_edge_lat", first_edge_cyc, acc_cyc);
    check_eq("final_level", sw, t);
    check_eq("done_count", done_cnt, 1);
    check_eq("settle_len", done_cyc - ((n_exp != 0) ? last_edge_cyc : acc_cyc), SC);
    check_eq("busy_len", busy_cnt, done_cyc - acc_cyc);
    tick();
    check_eq("ready_after", rdy, 1);
    check_eq("done_width", done, 0);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    req    = 1'b0;
    tgt    = 1'b0;
    req2   = 1'b0;
    tgt2   = 1'b0;
    mon_on = 0;
    tick();
    tick();
    check_eq("rst_sw", sw, 0);
    check_eq("rst_ready", rdy, 1);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_ready_small", rdy2, 1);
    rst_n = 1'b1;

    // press from reset with a fixed offset so the gap sequence can be replayed later
    run_seq(1'b1, 3, 0, 0);
    ref_gaps = gaps;
    check_eq("ref_gap_count", ref_gaps.size(), 2 * BC);

    run_seq(1'b0, $urandom_range(1, 10), 0, 0);

    // minimal configuration: single edge, done one cycle later
    check_eq("s_idle_ready", rdy2, 1);
    req2 = 1'b1;
    tgt2 = 1'b1;
    tick();
    req2 = 1'b0;
    check_eq("s_edge", sw2, 1);
    check_eq("s_busy", busy2, 1);
    check_eq("s_done_early", done2, 0);
    tick();
    check_eq("s_done", done2, 1);
    check_eq("s_ready_in_done", rdy2, 0);
    check_eq("s_level_hold", sw2, 1);
    tick();
    check_eq("s_ready_back", rdy2, 1);
    check_eq("s_done_width", done2, 0);

    // same-level request straight out of reset
    do_reset();
    run_seq(1'b0, $urandom_range(1, 10), 0, 0);

    // requests hammered while busy must be ignored
    run_seq(1'b1, $urandom_range(1, 10), 1, 0);
    run_seq(1'b0, $urandom_range(1, 10), 1, 0);

    // reset in the middle of the bounce burst
    do_reset();
    run_seq(1'b1, 3, 0, 5);
    check_eq("abort_level", sw, 1);
    mon_on = 0;
    rst_n  = 1'b0;
    tick();
    check_eq("abort_sw", sw, 0);
    check_eq("abort_ready", rdy, 1);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_done", done, 0);
    tick();
    check_eq("abort_no_done", done, 0);
    check_eq("abort_gap_n", gaps.size(), 4);
    n = (gaps.size() < 4) ? gaps.size() : 4;
    for (int i = 0; i < n; i++) check_eq("abort_gap", gaps[i], ref_gaps[i]);
    rst_n = 1'b1;

    run_seq(1'b1, 3, 0, 0);
    check_eq("replay_n", gaps.size(), ref_gaps.size());
    n = (gaps.size() < ref_gaps.size()) ? gaps.size() : ref_gaps.size();
    for (int i = 0; i < n; i++) check_eq("replay_gap", gaps[i], ref_gaps[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/switch_bounce_emulator.md
Name: switch_bounce_emulator

Overview:
- Synthesizable emulator of a mechanical switch: drives a bouncy 1-bit level that switch-input conditioning logic consumes.
- On a press/release request it makes the target edge, adds a burst of pseudo-random bounce toggles, then holds the target level through a settle window.
- Used for on-board self-test and for bench stimulus of debounce logic.

Parameters:
- BOUNCE_COUNT, 6, number of bounce pairs (away-and-back) after the first edge; 0 allowed.
- MIN_GAP, 64, minimum cycles between consecutive output edges; must be >= 1.
- GAP_BITS, 8, width of the random gap extension; extension range 0..2^GAP_BITS-1.
- SETTLE_CYCLES, 1000, cycles the final level is held before done; must be >= 1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- i_clk  in  1  sole clock
- i_rst_n  in  1  reset, synchronous, active-low
- i_req  in  1  request valid
- i_target  in  1  requested final switch level (1 = pressed)
- o_ready  out  1  high only in IDLE; request accepted when i_req && o_ready
- o_bouncy_switch  out  1  emulated switch level
- o_busy  out  1  high in BOUNCE or SETTLE
- o_done  out  1  one-cycle pulse at sequence completion

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous and active-low on i_rst_n.
- Reset values, one cycle after i_rst_n is sampled low: o_bouncy_switch=0, o_ready=1, o_busy=0, o_done=0, state IDLE, LFSR=LFSR_SEED.
- Reset mid-sequence: aborts immediately to the reset values above, with no o_done pulse.
- LFSR:
  - 16-bit Galois, taps x^16+x^14+x^13+x^11.
  - Free-running: advances every non-reset cycle.
  - Gap G = MIN_GAP + lfsr[GAP_BITS-1:0], sampled at the cycle the gap counter loads.
- States: IDLE, BOUNCE, SETTLE, DONE.
- IDLE, accept with i_target != o_bouncy_switch:
  - Next cycle o_bouncy_switch = i_target (first edge).
  - If BOUNCE_COUNT > 0: edges_left = 2*BOUNCE_COUNT, load gap, go to BOUNCE.
  - Else: load settle counter, go to SETTLE.
- IDLE, accept with i_target == o_bouncy_switch:
  - No output edge.
  - Go directly to SETTLE; the full settle window still applies.
- BOUNCE:
  - Each edge follows the previous one by exactly G cycles, with G re-sampled per edge.
  - At each edge: toggle the output, decrement edges_left.
  - When edges_left reaches 0 (output == target, since the count is even), load SETTLE_CYCLES and go to SETTLE.
- SETTLE:
  - Output constant.
  - o_done asserts exactly SETTLE_CYCLES cycles after the last edge, or after acceptance for a no-edge request.
  - State moves to DONE in that cycle.
- DONE: o_done=1 for this single cycle, o_ready=0; next cycle IDLE.
- Request timing:
  - i_req while not ready is ignored, not queued.
  - Earliest next acceptance is the cycle after o_done.
- Latched target: i_target is latched at acceptance; later changes have no effect.
- Counter widths:
  - Gap counter: $clog2(MIN_GAP + 2^GAP_BITS) bits.
  - Settle counter: $clog2(SETTLE_CYCLES + 1) bits.
  - edges_left: $clog2(2*BOUNCE_COUNT + 1) bits.
  - No wrap-around is reachable; down-counters stop at 0.
- Max sequence length: 1 + 2*BOUNCE_COUNT*(MIN_GAP + 2^GAP_BITS - 1) + SETTLE_CYCLES + 1 cycles.
- o_bouncy_switch is registered and glitch-free: it changes only on i_clk edges.

Decomposition:
- Shared package contents:
  - state enum {IDLE, BOUNCE, SETTLE, DONE};
  - LFSR width and tap constant 16'hB400.
- Sub-module lfsr16:
  - Ports: clock, sync active-low reset, seed parameter, 16-bit state out.
  - Reused by other stimulus blocks.

Test Plan:
- Press with defaults: reset, then i_req=1, i_target=1 for 1 cycle.
  - Required: output rises 1 cycle after accept.
  - Exactly 13 edges total.
  - Each inter-edge gap within 64..319 and matching the LFSR model.
  - Final level 1.
  - o_done exactly 1000 cycles after the last edge, width 1.
- Release after press: i_target=0.
  - Required: mirrored sequence, 13 edges, final level 0, o_done once.
- No-edge request: i_target=0 from reset.
  - Required: zero output edges.
  - o_busy high 1000 cycles.
  - o_done 1000 cycles after accept.
- BOUNCE_COUNT=0, MIN_GAP=1, GAP_BITS=1, SETTLE_CYCLES=1, press.
  - Required: single edge, o_done 1 cycle after it.
  - o_ready back high the following cycle.
- Busy rejection: assert i_req with i_target toggling every cycle during BOUNCE.
  - Required: no extra acceptance.
  - Edge count and final level follow the original latched target.
- Reset mid-BOUNCE, after 5 edges, with the output at 1.
  - Required: next cycle output 0, o_ready 1, no o_done.
  - A following press replays an LFSR gap sequence identical to the first run.
